// File: rtl/sdram_pattern_gen.sv
// sdram_pattern_gen: memory test sequencer for an SDRAM controller port.
// Sweeps 2^AW words with a selectable pattern (write pass, then read/compare pass),
// repeated PASSES times per start. Mismatches are counted and the first failing
// address is captured.
// Build option: define SDRAM_PATTERN_TIMEOUT_EN to add a 10-bit request watchdog;
// without it timeout is tied low and the block waits indefinitely on the controller.
module sdram_pattern_gen #(
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 21,
    parameter int unsigned PASSES = 1
) (
    input  logic          clk_in,
    input  logic          zusr_key,
    input  logic          start,
    input  logic [1:0]    mode,
    output logic          cmd_req,
    output logic          cmd_wr,
    output logic [AW-1:0] cmd_addr,
    output logic [DW-1:0] cmd_wdata,
    input  logic          cmd_ack,
    input  logic          rd_valid,
    input  logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [15:0]   err_cnt,
    output logic [AW-1:0] err_addr
);

    localparam logic [31:0]   LFSR_SEED = 32'hACE1_2468;
    // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0]   LFSR_POLY = 32'h8020_0003;
    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
    localparam logic [7:0]    LAST_PASS = 8'(PASSES - 1);
    localparam logic [15:0]   ERR_MAX   = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_RD_REQ,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [1:0]    r_mode;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_pass_cnt;
    logic [31:0]   r_lfsr;
    logic          r_cmd_req;
    logic          r_cmd_wr;
    logic [DW-1:0] r_wdata;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic [15:0]   r_err_cnt;
    logic [AW-1:0] r_err_addr;

    logic [AW-1:0] w_addr_nxt;
    logic [31:0]   w_lfsr_nxt;
    logic [DW-1:0] w_expect;
    logic          w_mismatch;
    logic [15:0]   w_err_nxt;
    logic          w_last;

    // One LFSR advance per word
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    // Data word for an address under the selected pattern
    function automatic logic [DW-1:0] pattern_of(input logic [1:0] m, input logic [AW-1:0] a,
                                                 input logic [31:0] s);
        logic [DW-1:0] v;
        case (m)
            2'd0:    v = DW'(a);
            2'd1:    v = ~DW'(a);
            2'd2:    v = s[DW-1:0];
            default: v = DW'(1) << (32'(a) % DW);
        endcase
        return v;
    endfunction

    assign w_addr_nxt = r_addr + AW'(1);
    assign w_lfsr_nxt = lfsr_step(r_lfsr);
    assign w_expect   = pattern_of(r_mode, r_addr, r_lfsr);
    assign w_mismatch = (rd_data != w_expect);
    assign w_err_nxt  = (w_mismatch && (r_err_cnt != ERR_MAX)) ? r_err_cnt + 16'd1 : r_err_cnt;
    assign w_last     = (r_addr == LAST_ADDR);

`ifdef SDRAM_PATTERN_TIMEOUT_EN
    localparam logic [9:0] WD_LIMIT = 10'd1023;
    logic [9:0] r_wd;
    logic       r_timeout;
    logic       w_waiting;
    logic       w_progress;
    logic       w_wd_expire;

    assign w_waiting   = (r_state == S_WR_REQ) || (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);
    assign w_progress  = (((r_state == S_WR_REQ) || (r_state == S_RD_REQ)) && cmd_ack) ||
                         ((r_state == S_RD_WAIT) && rd_valid);
    // The stalled cycle that brings the count to 1023
    assign w_wd_expire = (r_wd == (WD_LIMIT - 10'd1));
    assign timeout     = r_timeout;
`else
    assign timeout     = 1'b0;
`endif

    assign cmd_req   = r_cmd_req;
    assign cmd_wr    = r_cmd_wr;
    assign cmd_addr  = r_addr;
    assign cmd_wdata = r_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_cnt   = r_err_cnt;
    assign err_addr  = r_err_addr;

    // Sequencer FSM with registered request and status outputs
    always_ff @(posedge clk_in) begin
        if (!zusr_key) begin
            r_state    <= S_IDLE;
            r_mode     <= 2'd0;
            r_addr     <= '0;
            r_pass_cnt <= 8'd0;
            r_lfsr     <= 32'h0;
            r_cmd_req  <= 1'b0;
            r_cmd_wr   <= 1'b0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= 16'd0;
            r_err_addr <= '0;
`ifdef SDRAM_PATTERN_TIMEOUT_EN
            r_wd       <= 10'd0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_WR_REQ;
                        r_mode     <= mode;
                        r_addr     <= '0;
                        r_pass_cnt <= 8'd0;
                        r_lfsr     <= LFSR_SEED;
                        r_cmd_req  <= 1'b1;
                        r_cmd_wr   <= 1'b1;
                        r_wdata    <= pattern_of(mode, AW'(0), LFSR_SEED);
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_err_cnt  <= 16'd0;
                        r_err_addr <= '0;
                    end
                end
                S_WR_REQ: begin
                    if (cmd_ack) begin
                        if (w_last) begin
                            r_state  <= S_RD_REQ;
                            r_addr   <= '0;
                            r_lfsr   <= LFSR_SEED;
                            r_cmd_wr <= 1'b0;
                        end else begin
                            r_addr  <= w_addr_nxt;
                            r_lfsr  <= w_lfsr_nxt;
                            r_wdata <= pattern_of(r_mode, w_addr_nxt, w_lfsr_nxt);
                        end
                    end
                end
                S_RD_REQ: begin
                    if (cmd_ack) begin
                        r_state   <= S_RD_WAIT;
                        r_cmd_req <= 1'b0;
                    end
                end
                S_RD_WAIT: begin
                    if (rd_valid) begin
                        r_err_cnt <= w_err_nxt;
                        if (w_mismatch && (r_err_cnt == 16'd0)) r_err_addr <= r_addr;
                        if (!w_last) begin
                            r_state   <= S_RD_REQ;
                            r_addr    <= w_addr_nxt;
                            r_lfsr    <= w_lfsr_nxt;
                            r_cmd_req <= 1'b1;
                        end else if (r_pass_cnt == LAST_PASS) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_nxt == 16'd0);
                        end else begin
                            r_state    <= S_WR_REQ;
                            r_pass_cnt <= r_pass_cnt + 8'd1;
                            r_addr     <= '0;
                            r_lfsr     <= LFSR_SEED;
                            r_cmd_req  <= 1'b1;
                            r_cmd_wr   <= 1'b1;
                            r_wdata    <= pattern_of(r_mode, AW'(0), LFSR_SEED);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef SDRAM_PATTERN_TIMEOUT_EN
            // Watchdog overrides the case above when the controller stalls too long
            if (((r_state == S_IDLE) || (r_state == S_DONE)) && start) r_timeout <= 1'b0;
            if (!w_waiting || w_progress) begin
                r_wd <= 10'd0;
            end else if (w_wd_expire) begin
                r_wd      <= 10'd0;
                r_timeout <= 1'b1;
                r_state   <= S_DONE;
                r_cmd_req <= 1'b0;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_pass    <= 1'b0;
            end else begin
                r_wd <= r_wd + 10'd1;
            end
`endif
        end
    end

endmodule
